// File: rtl/adbg_wb_burst_pkg.sv
// rtl/adbg_wb_burst_pkg.sv - shared states, word sizes and lane helpers for the debug burst sequencer
package adbg_wb_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_ISSUE,
        S_WAIT,
        S_RDATA,
        S_DONE
    } state_e;

    localparam logic [3:0] SZ_BYTE = 4'd1;
    localparam logic [3:0] SZ_HALF = 4'd2;
    localparam logic [3:0] SZ_WORD = 4'd4;

    // Anything the decoder sends that is not a byte or half is treated as a full word.
    function automatic logic [3:0] norm_size(input logic [3:0] sz);
        return (sz == SZ_BYTE || sz == SZ_HALF) ? sz : SZ_WORD;
    endfunction

    function automatic logic [3:0] size_to_step(input logic [3:0] sz);
        return norm_size(sz);
    endfunction

    function automatic logic [31:0] msb_justify(input logic [3:0] sz, input logic [31:0] d);
        case (norm_size(sz))
            SZ_BYTE: return {d[7:0], 24'h0};
            SZ_HALF: return {d[15:0], 16'h0};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] lsb_extract(input logic [3:0] sz, input logic [31:0] d);
        case (norm_size(sz))
            SZ_BYTE: return {24'h0, d[7:0]};
            SZ_HALF: return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/adbg_wb_burst_align.sv
// rtl/adbg_wb_burst_align.sv - byte-lane justification between the word streams and the BIU
module adbg_wb_burst_align
    import adbg_wb_burst_pkg::*;
(
    input  logic [3:0]  word_size_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rd_raw_i,
    output logic [31:0] wr_just_o,
    output logic [31:0] rd_just_o
);

    assign wr_just_o = msb_justify(word_size_i, wr_data_i);
    assign rd_just_o = lsb_extract(word_size_i, rd_raw_i);

endmodule

// File: rtl/adbg_wb_burst_ctrl.sv
// rtl/adbg_wb_burst_ctrl.sv - debug Wishbone burst sequencer feeding the BIU one word at a time
module adbg_wb_burst_ctrl
    import adbg_wb_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  biu_clk,
    input  logic                  biu_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [3:0]            cmd_word_size,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  cmd_rw,
    input  logic                  abort,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  biu_strb,
    output logic                  biu_rw,
    output logic [ADDR_WIDTH-1:0] biu_addr,
    output logic [3:0]            biu_word_size,
    output logic [DATA_WIDTH-1:0] biu_di,
    input  logic                  biu_rdy,
    input  logic [DATA_WIDTH-1:0] biu_do,
    input  logic                  biu_err
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [3:0]            size_q, size_d;
    logic                  rw_q, rw_d;
    logic                  err_q, err_d;
    logic                  abort_q, abort_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_dec;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wr_just, rd_just;
    logic                  abort_seen;

    adbg_wb_burst_align u_align (
        .word_size_i (size_q),
        .wr_data_i   (wr_data),
        .rd_raw_i    (biu_do),
        .wr_just_o   (wr_just),
        .rd_just_o   (rd_just)
    );

    assign cnt_dec    = cnt_q - CNT_WIDTH'(1);
    assign abort_seen = abort_q | abort;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        size_d     = size_q;
        rw_d       = rw_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        di_d       = di_q;
        rd_d       = rd_q;
        abort_d    = abort_q | (abort && state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    size_d     = norm_size(cmd_word_size);
                    rw_d       = cmd_rw;
                    cnt_d      = cmd_count;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                    abort_d    = 1'b0;
                    if (cmd_count == '0)  state_d = S_DONE;
                    else if (cmd_rw)      state_d = S_ISSUE;
                    else                  state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                // A word offered together with abort is still written; abort only wins on an empty slot.
                if (wr_valid) begin
                    di_d    = wr_just;
                    state_d = S_ISSUE;
                end else if (abort_seen) begin
                    state_d = S_DONE;
                end
            end
            S_ISSUE: begin
                if (biu_rdy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (biu_rdy) begin
                    if (biu_err && !err_q) err_addr_d = addr_q;
                    err_d  = err_q | biu_err;
                    cnt_d  = cnt_dec;
                    addr_d = addr_q + ADDR_WIDTH'(size_to_step(size_q));
                    if (rw_q) begin
                        rd_d    = rd_just;
                        state_d = S_RDATA;
                    end else if (cnt_dec == '0 || abort_seen) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_RDATA: begin
                if (rd_ready) state_d = (cnt_q == '0 || abort_seen) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge biu_clk or posedge biu_rst) begin
        if (biu_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            err_addr_q <= '0;
            size_q     <= SZ_WORD;
            rw_q       <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= '0;
            di_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            size_q     <= size_d;
            rw_q       <= rw_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            cnt_q      <= cnt_d;
            di_q       <= di_d;
            rd_q       <= rd_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign wr_ready      = (state_q == S_WDATA);
    assign rd_valid      = (state_q == S_RDATA);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign biu_strb      = (state_q == S_ISSUE);
    assign rd_data       = rd_q;
    assign err           = err_q;
    assign err_addr      = err_addr_q;
    assign biu_rw        = rw_q;
    assign biu_addr      = addr_q;
    assign biu_word_size = size_q;
    assign biu_di        = di_q;

endmodule

// File: doc/adbg_wb_burst_ctrl.md
Name: adbg_wb_burst_ctrl

Overview:
- Burst sequencer for the debug Wishbone path, directly upstream of the Wishbone BIU.
- Accepts one burst command (start address, word size, word count, direction) from the debug command decoder.
- Issues the words one by one over the biu_* strobe/ready handshake, advancing the address each word.
- Moves data between ready/valid write/read streams and the BIU, handles byte-lane justification and reports errors.

Parameters:
- ADDR_WIDTH, 32, address width; equals BIU ADDR_WIDTH.
- DATA_WIDTH, 32, data width; only 32 supported.
- CNT_WIDTH, 16, width of word-count field.

Ports:
- biu_clk  in  1  clock (TCK domain).
- biu_rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_word_size  in  4  bytes per word: 1, 2 or 4.
- cmd_count  in  CNT_WIDTH  number of words.
- cmd_rw  in  1  1=read, 0=write.
- abort  in  1  stop burst after the in-flight access.
- wr_valid  in  1  write word valid.
- wr_ready  out  1  write word consumed.
- wr_data  in  32  write word, right-justified.
- rd_valid  out  1  read word valid.
- rd_ready  in  1  read word consumed.
- rd_data  out  32  read word, right-justified, unused MSBs zero.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  sticky: any access in the current/last burst returned biu_err.
- err_addr  out  ADDR_WIDTH  address of the first errored access.
- biu_strb  out  1  access strobe to BIU.
- biu_rw  out  1  1=read.
- biu_addr  out  ADDR_WIDTH  access address.
- biu_word_size  out  4  access size.
- biu_di  out  32  write data, MSB-justified.
- biu_rdy  in  1  BIU ready/access complete.
- biu_do  in  32  read data, LSB-justified.
- biu_err  in  1  access error; valid when biu_rdy rises.

Behaviour:
- Reset values (async): state IDLE; cmd_ready=1; wr_ready=0; rd_valid=0; rd_data=0; busy=0; done=0; err=0; err_addr=0; biu_strb=0; biu_rw=0; biu_addr=0; biu_word_size=4; biu_di=0.
- Reset mid-burst returns to IDLE immediately. No done pulse. BIU is reset by the same signal.
- Command latch:
  - Word size is normalised: values other than 1 and 2 become 4.
  - Address step is 1, 2 or 4 bytes; address wraps modulo 2^ADDR_WIDTH.
  - Accepting a command clears err and err_addr, and loads the remaining-word counter with cmd_count.
  - cmd_count=0: command accepted, no bus access, done pulses the next cycle.
- FSM states: IDLE, WDATA, ISSUE, WAIT, RDATA, DONE.
- IDLE -> WDATA (write) or ISSUE (read) on command accept, count≠0. busy=1 in every state except IDLE.
- WDATA:
  - wr_ready=1.
  - On wr_valid, latch biu_di with write data MSB-justified: byte uses wr_data[7:0] placed at [31:24]; half uses [15:0] placed at [31:16]; word is passed unchanged.
  - Then go to ISSUE.
- ISSUE:
  - biu_strb=1 only while in ISSUE.
  - When biu_strb&&biu_rdy: go to WAIT.
  - If biu_rdy=0, hold strobe.
- WAIT:
  - biu_strb=0; wait for biu_rdy=1.
  - On completion: if biu_err and err=0, capture err_addr=biu_addr. Set err|=biu_err.
  - Decrement the counter and advance biu_addr.
  - Read: rd_data = biu_do masked to size (byte [7:0], half [15:0]), rd_valid=1 -> RDATA.
  - Write: counter==0 or abort seen -> DONE, else -> WDATA.
- RDATA:
  - Hold rd_valid/rd_data until rd_ready.
  - Then: counter==0 or abort seen -> DONE, else -> ISSUE.
- DONE: done=1 for one cycle -> IDLE, cmd_ready=1.
- Errors do not stop the burst. Remaining words still transfer; read data is returned as-is.
- abort:
  - Sampled any cycle while busy; remembered until DONE.
  - Asserted in WDATA with no word taken: go straight to DONE.
  - Never truncates an access whose strobe was accepted.
- Latency: read word at earliest 2 cycles after strobe acceptance plus BIU turnaround. Exactly one access outstanding at all times.

Decomposition:
- Package adbg_wb_burst_pkg: FSM state enum; word-size constants (SZ_BYTE=1, SZ_HALF=2, SZ_WORD=4).
- Package function: size-to-step, and MSB/LSB justification helpers.
- Sub-module adbg_wb_burst_align: combinational write MSB-justify and read mask/extract. Pure function of word size and data; keeps the FSM file clean.

Test Plan:
- Write burst: addr 0x1000, size 4, count 3, data 0xA,0xB,0xC; BIU model 2-cycle turnaround -> strobes at 0x1000/0x1004/0x1008 with biu_di 0xA/0xB/0xC; one done pulse; err=0.
- Read burst of bytes: addr 0x2003, size 1, count 2; biu_do 0x55 then 0x66 -> addrs 0x2003, 0x2004; rd_data 0x55, 0x66; upper bits zero.
- Half-word write 0x1234 -> biu_di=0x12340000. Address wrap: start 0xFFFFFFFE, size 2, count 2 -> second address 0x00000000.
- Error mid-burst: biu_err=1 on word 2 of 4 at 0x3000 (size 4) -> all 4 accesses issued; err=1; err_addr=0x3004; next command clears err.
- Backpressure and abort: read count 4 with rd_ready low 5 cycles -> no new strobe until consumed; abort during word 2's WAIT -> no third strobe, done pulses.
- Corner cases:
  - cmd_count=0 -> no strobe, done the cycle after accept.
  - biu_rst asserted during WAIT -> all outputs at reset values the same cycle; cmd_ready=1.
